elevator_call_scheduler: RTL and testbench

//   Call latching and SCAN scheduling for the 3-floor elevator (ground/first/second).

---
 rtl/elevator_call_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// Call latching and SCAN scheduling for a 3-floor elevator car with door timing and emergency stop.
// Optional park-to-ground after PARK_CYC idle cycles is enabled by defining PARK_GROUND_EN.
module elevator_call_scheduler #(
    parameter int TRAVEL_CYC = 8,
    parameter int DOOR_CYC   = 4,
    parameter int PARK_CYC   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       g_f,
    input  logic       f_f,
    input  logic       s_f,
    input  logic       emerg_in,
    output logic       emerg_out,
    output logic       move_up,
    output logic       move_down,
    output logic       door_open,
    output logic [2:0] pending,
    output logic [3:0] Disp_1,
    output logic [3:0] Disp_2
);

    localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYC - 1);
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DOOR  = 2'd2,
        ST_EMERG = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    floor_q, floor_d;
    logic          dir_q, dir_d;
    logic [2:0]    pending_q, pending_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          emerg_out_q, emerg_out_d;
    logic          move_up_q, move_up_d;
    logic          move_down_q, move_down_d;
    logic          door_open_q, door_open_d;
    logic [3:0]    disp_2_q, disp_2_d;

    logic [2:0]    calls_s;
    logic [2:0]    cur_oh_s;
    logic [1:0]    next_floor_s;
    logic [2:0]    next_oh_s;
    logic [2:0]    ahead_s;
    logic [2:0]    behind_s;
    logic          at_end_s;
    logic          park_go_s;

    function automatic logic [2:0] floor_onehot(input logic [1:0] f);
        case (f)
            2'd0:    floor_onehot = 3'b001;
            2'd1:    floor_onehot = 3'b010;
            2'd2:    floor_onehot = 3'b100;
            default: floor_onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] above_mask(input logic [1:0] f);
        case (f)
            2'd0:    above_mask = 3'b110;
            2'd1:    above_mask = 3'b100;
            default: above_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input logic [1:0] f);
        case (f)
            2'd0:    below_mask = 3'b000;
            2'd1:    below_mask = 3'b001;
            default: below_mask = 3'b011;
        endcase
    endfunction

    // Nearest latched floor strictly beyond f in direction d, 4'hF when none.
    function automatic logic [3:0] target_in_dir(input logic [2:0] p, input logic [1:0] f, input logic d);
        logic [2:0] a;
        logic [2:0] b;
        a = p & above_mask(f);
        b = p & below_mask(f);
        if (d == DIR_UP) begin
            if (a[1])      target_in_dir = 4'd1;
            else if (a[2]) target_in_dir = 4'd2;
            else           target_in_dir = 4'hF;
        end else begin
            if (b[1])      target_in_dir = 4'd1;
            else if (b[0]) target_in_dir = 4'd0;
            else           target_in_dir = 4'hF;
        end
    endfunction

    assign calls_s      = {s_f, f_f, g_f};
    assign cur_oh_s     = floor_onehot(floor_q);
    assign next_floor_s = (dir_q == DIR_UP) ? (floor_q + 2'd1) : (floor_q - 2'd1);
    assign next_oh_s    = floor_onehot(next_floor_s);
    assign ahead_s      = pending_q & ((dir_q == DIR_UP) ? above_mask(floor_q) : below_mask(floor_q));
    assign behind_s     = pending_q & ((dir_q == DIR_UP) ? below_mask(floor_q) : above_mask(floor_q));
    assign at_end_s     = (dir_q == DIR_UP) ? (next_floor_s == 2'd2) : (next_floor_s == 2'd0);

`ifdef PARK_GROUND_EN
    localparam int PW = $clog2(PARK_CYC + 1);
    logic [PW-1:0] idle_cnt_q, idle_cnt_d;
    logic          idle_ok_s;

    assign idle_ok_s = (state_q == ST_IDLE) && !emerg_in && (calls_s == 3'b000)
                       && (pending_q == 3'b000) && (floor_q != 2'd0);
    assign park_go_s = idle_ok_s && (idle_cnt_q == PW'(PARK_CYC - 1));

    // Idle counter: any call, emergency or leaving IDLE restarts it.
    always_comb begin
        idle_cnt_d = '0;
        if (idle_ok_s && !park_go_s) begin
            idle_cnt_d = idle_cnt_q + PW'(1);
        end else begin
            idle_cnt_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    // Parking disabled: PARK_CYC only keeps the parameter list identical across builds.
    assign park_go_s = 1'b0 && (PARK_CYC > 0);
`endif

    // Next-state: emergency first, then per-state scheduling.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        if (emerg_in) begin
            state_d   = ST_EMERG;
            pending_d = 3'b000;
            timer_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pending_d = pending_q | (calls_s & ~cur_oh_s);
                    timer_d   = '0;
                    if (((calls_s | pending_q) & cur_oh_s) != 3'b000) begin
                        state_d   = ST_DOOR;
                        pending_d = pending_d & ~cur_oh_s;
                    end else if (pending_q != 3'b000) begin
                        state_d = ST_MOVE;
                        dir_d   = ((pending_q & above_mask(floor_q)) != 3'b000) ? DIR_UP : DIR_DN;
                    end else if (park_go_s) begin
                        state_d = ST_MOVE;
                        dir_d   = DIR_DN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MOVE: begin
                    pending_d = pending_q | calls_s;
                    if (timer_q == TRAVEL_LAST) begin
                        floor_d = next_floor_s;
                        timer_d = '0;
                        if ((pending_q & next_oh_s) != 3'b000) begin
                            state_d   = ST_DOOR;
                            pending_d = pending_d & ~next_oh_s;
                        end else if (at_end_s) begin
                            // End of shaft with nothing to serve (park arrival): stop, door stays shut.
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_MOVE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_DOOR: begin
                    pending_d = pending_q | (calls_s & ~cur_oh_s);
                    if ((calls_s & cur_oh_s) != 3'b000) begin
                        timer_d = '0;
                    end else if (timer_q == DOOR_LAST) begin
                        timer_d = '0;
                        if (ahead_s != 3'b000) begin
                            state_d = ST_MOVE;
                        end else if (behind_s != 3'b000) begin
                            state_d = ST_MOVE;
                            dir_d   = ~dir_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_EMERG: begin
                    state_d   = ST_IDLE;
                    pending_d = 3'b000;
                    timer_d   = '0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    pending_d = 3'b000;
                    timer_d   = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they land in flops alongside it.
    always_comb begin
        emerg_out_d = (state_d == ST_EMERG);
        door_open_d = (state_d == ST_DOOR) || (state_d == ST_EMERG);
        move_up_d   = (state_d == ST_MOVE) && (dir_d == DIR_UP);
        move_down_d = (state_d == ST_MOVE) && (dir_d == DIR_DN);
        case (state_d)
            ST_MOVE: disp_2_d = target_in_dir(pending_d, floor_d, dir_d);
            ST_DOOR: disp_2_d = {2'b00, floor_d};
            default: disp_2_d = 4'hF;
        endcase
    end

    // State, position and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            floor_q     <= 2'd0;
            dir_q       <= DIR_UP;
            pending_q   <= 3'b000;
            timer_q     <= '0;
            emerg_out_q <= 1'b0;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
            door_open_q <= 1'b0;
            disp_2_q    <= 4'hF;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            emerg_out_q <= emerg_out_d;
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
            door_open_q <= door_open_d;
            disp_2_q    <= disp_2_d;
        end
    end

    assign emerg_out = emerg_out_q;
    assign move_up   = move_up_q;
    assign move_down = move_down_q;
    assign door_open = door_open_q;
    assign pending   = pending_q;
    assign Disp_1    = {2'b00, floor_q};
    assign Disp_2    = disp_2_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios then random calls, every cycle compared
// against a behavioural model of the call/SCAN rules.
module tb_elevator_call_scheduler;

    localparam int TRAVEL_CYC = 8;
    localparam int DOOR_CYC   = 4;
    localparam int PARK_CYC   = 16;
    localparam int M_IDLE  = 0;
    localparam int M_MOVE  = 1;
    localparam int M_DOOR  = 2;
    localparam int M_EMERG = 3;

    logic       clk;
    logic       reset;
    logic       g_f, f_f, s_f, emerg_in;
    logic       emerg_out, move_up, move_down, door_open;
    logic [2:0] pending;
    logic [3:0] Disp_1, Disp_2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: abstract car state; m_left counts remaining cycles of the current phase.
    int       m_st, m_fl, m_left, m_idle;
    bit       m_up;
    bit [2:0] m_p;

    elevator_call_scheduler #(
        .TRAVEL_CYC(TRAVEL_CYC),
        .DOOR_CYC  (DOOR_CYC),
        .PARK_CYC  (PARK_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .g_f      (g_f),
        .f_f      (f_f),
        .s_f      (s_f),
        .emerg_in (emerg_in),
        .emerg_out(emerg_out),
        .move_up  (move_up),
        .move_down(move_down),
        .door_open(door_open),
        .pending  (pending),
        .Disp_1   (Disp_1),
        .Disp_2   (Disp_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_st = M_IDLE; m_fl = 0; m_up = 1'b1; m_left = 0; m_idle = 0; m_p = 3'b000;
    endfunction

    function automatic bit any_beyond(int fl, bit up);
        for (int f = 0; f < 3; f++)
            if (m_p[f] && (up ? (f > fl) : (f < fl))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(logic [2:0] c, logic e);
        bit [2:0] np;
        np = m_p;
        if (e) begin
            m_st = M_EMERG; np = 3'b000; m_idle = 0;
        end else if (m_st == M_EMERG) begin
            m_st = M_IDLE; m_idle = 0;
        end else if (m_st == M_IDLE) begin
            for (int i = 0; i < 3; i++) if (c[i] && i != m_fl) np[i] = 1'b1;
            if (c[m_fl] || m_p[m_fl]) begin
                m_st = M_DOOR; m_left = DOOR_CYC; np[m_fl] = 1'b0; m_idle = 0;
            end else if (m_p != 3'b000) begin
                m_st = M_MOVE; m_left = TRAVEL_CYC; m_up = any_beyond(m_fl, 1'b1); m_idle = 0;
`ifdef PARK_GROUND_EN
            end else if (m_fl != 0 && c == 3'b000) begin
                m_idle++;
                if (m_idle == PARK_CYC) begin
                    m_st = M_MOVE; m_left = TRAVEL_CYC; m_up = 1'b0; m_idle = 0;
                end
`endif
            end else begin
                m_idle = 0;
            end
        end else if (m_st == M_MOVE) begin
            np = m_p | c;
            m_idle = 0;
            m_left--;
            if (m_left == 0) begin
                m_fl = m_up ? m_fl + 1 : m_fl - 1;
                if (m_p[m_fl]) begin
                    m_st = M_DOOR; m_left = DOOR_CYC; np[m_fl] = 1'b0;
                end else if (m_fl == 0 || m_fl == 2) begin
                    m_st = M_IDLE;
                end else begin
                    m_left = TRAVEL_CYC;
                end
            end
        end else begin
            m_idle = 0;
            for (int i = 0; i < 3; i++) if (c[i] && i != m_fl) np[i] = 1'b1;
            if (c[m_fl]) begin
                m_left = DOOR_CYC;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (any_beyond(m_fl, m_up)) begin
                        m_st = M_MOVE; m_left = TRAVEL_CYC;
                    end else if (any_beyond(m_fl, !m_up)) begin
                        m_st = M_MOVE; m_left = TRAVEL_CYC; m_up = !m_up;
                    end else begin
                        m_st = M_IDLE;
                    end
                end
            end
        end
        m_p = np;
    endfunction

    function automatic logic [3:0] model_disp2();
        int f;
        if (m_st == M_MOVE) begin
            for (int d = 1; d <= 2; d++) begin
                f = m_up ? m_fl + d : m_fl - d;
                if (f >= 0 && f <= 2 && m_p[f]) return 4'(f);
            end
            return 4'hF;
        end else if (m_st == M_DOOR) begin
            return 4'(m_fl);
        end
        return 4'hF;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("emerg_out", 8'(emerg_out), 8'(m_st == M_EMERG));
        check("door_open", 8'(door_open), 8'(m_st == M_DOOR || m_st == M_EMERG));
        check("move_up",   8'(move_up),   8'(m_st == M_MOVE && m_up));
        check("move_down", 8'(move_down), 8'(m_st == M_MOVE && !m_up));
        check("pending",   8'(pending),   8'(m_p));
        check("Disp_1",    8'(Disp_1),    8'(m_fl));
        check("Disp_2",    8'(Disp_2),    8'(model_disp2()));
    endtask

    task automatic tick(input logic [2:0] c, input logic e);
        @(negedge clk);
        g_f = c[0]; f_f = c[1]; s_f = c[2]; emerg_in = e;
        @(posedge clk);
        model_step(c, e);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        g_f = 1'b0; f_f = 1'b0; s_f = 1'b0; emerg_in = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();
    endtask

    task automatic wait_floor(input logic [3:0] fl, output int n);
        n = 0;
        while (Disp_1 !== fl && n < 64) begin
            tick(3'b000, 1'b0);
            n++;
        end
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (door_open === 1'b1 && n < 32) begin
            tick(3'b000, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        int ehold;
        logic [2:0] c;
        reset = 1'b1; g_f = 1'b0; f_f = 1'b0; s_f = 1'b0; emerg_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();
        check("reset_disp2", 8'(Disp_2), 8'h0F);

        // 1: call at the current floor opens the door without latching
        tick(3'b001, 1'b0);
        check("t1_door", 8'(door_open), 8'd1);
        check("t1_pend", 8'(pending), 8'd0);
        count_door(n);
        check("t1_door_len", 8'(n), 8'(DOOR_CYC));

        // 2: ground to second floor
        tick(3'b100, 1'b0);
        tick(3'b000, 1'b0);
        check("t2_up", 8'(move_up), 8'd1);
        check("t2_target", 8'(Disp_2), 8'd2);
        wait_floor(4'd1, n);
        check("t2_travel_01", 8'(n), 8'(TRAVEL_CYC));
        wait_floor(4'd2, n);
        check("t2_travel_12", 8'(n), 8'(TRAVEL_CYC));
        check("t2_door", 8'(door_open), 8'd1);
        count_door(n);
        check("t2_door_len", 8'(n), 8'(DOOR_CYC));
        check("t2_pend", 8'(pending), 8'd0);

        // 5: idle at the second floor
`ifdef PARK_GROUND_EN
        repeat (PARK_CYC) tick(3'b000, 1'b0);
        check("t5_park_down", 8'(move_down), 8'd1);
        wait_floor(4'd0, n);
        check("t5_park_travel", 8'(n), 8'(2 * TRAVEL_CYC));
        check("t5_park_nodoor", 8'(door_open), 8'd0);
`else
        repeat (PARK_CYC + 4) tick(3'b000, 1'b0);
        check("t5_stay_floor", 8'(Disp_1), 8'd2);
        check("t5_no_move", 8'(move_down), 8'd0);
`endif

        // 3: intermediate call picked up on the way
        do_reset();
        tick(3'b100, 1'b0);
        repeat (3) tick(3'b000, 1'b0);
        tick(3'b010, 1'b0);
        check("t3_pend_110", 8'(pending), 8'b110);
        wait_floor(4'd1, n);
        check("t3_stop_1", 8'(door_open), 8'd1);
        check("t3_pend_100", 8'(pending), 8'b100);
        count_door(n);
        check("t3_resume_up", 8'(move_up), 8'd1);
        wait_floor(4'd2, n);
        check("t3_stop_2", 8'(door_open), 8'd1);
        check("t3_pend_000", 8'(pending), 8'd0);

        // 4: emergency mid-travel
        do_reset();
        tick(3'b100, 1'b0);
        repeat (3) tick(3'b000, 1'b0);
        tick(3'b001, 1'b0);
        check("t4_pend_101", 8'(pending), 8'b101);
        tick(3'b000, 1'b1);
        check("t4_emerg", 8'(emerg_out), 8'd1);
        check("t4_stop", 8'({move_up, move_down}), 8'd0);
        check("t4_pend_clr", 8'(pending), 8'd0);
        tick(3'b111, 1'b1);
        check("t4_ignore", 8'(pending), 8'd0);
        tick(3'b000, 1'b0);
        check("t4_release", 8'(emerg_out), 8'd0);
        check("t4_floor_held", 8'(Disp_1), 8'd0);

        // 6: reset asserted between floors
        tick(3'b100, 1'b0);
        repeat (4) tick(3'b000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check("t6_up_off", 8'(move_up), 8'd0);
        check("t6_disp2", 8'(Disp_2), 8'h0F);
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();

        // Random calls and emergency bursts
        ehold = 0;
        for (int i = 0; i < 3000; i++) begin
            c[0] = ($urandom_range(0, 11) == 0);
            c[1] = ($urandom_range(0, 11) == 0);
            c[2] = ($urandom_range(0, 11) == 0);
            if (ehold == 0 && $urandom_range(0, 149) == 0) ehold = $urandom_range(1, 4);
            tick(c, ehold != 0);
            if (ehold != 0) ehold--;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
